// File: rtl/alu_if.sv
// alu_pkg / alu_if
//   alu_pkg : shared widths and the decoded instruction-type encoding used by
//             the reservation station and the integer execute stage.
//   alu_if  : RS issue port plus the ALU common data bus.
//     issue  (RS -> ALU): alu_en_in, alu_vj_in, alu_vk_in, alu_A_in,
//                         alu_dest_in, alu_pc_in, alu_inst_type_in
//     cdb    (ALU -> RS/LB/ROB): cdb_alu_en_out, cdb_alu_dest_out,
//                         cdb_alu_value_out, cdb_alu_jump_out, cdb_alu_target_out
//   Modports: slave = ALU side, master = RS/bench side.
package alu_pkg;
    localparam int unsigned INSTRUCTION_WIDTH = 32;
    localparam int unsigned ADDRESS_WIDTH     = 32;
    localparam int unsigned ROB_WIDTH         = 4;
    localparam int unsigned INST_TYPE_WIDTH   = 6;

    typedef enum logic [INST_TYPE_WIDTH-1:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
    } inst_type_e;
endpackage

interface alu_if;
    import alu_pkg::*;

    logic                         alu_en_in;
    logic [INSTRUCTION_WIDTH-1:0] alu_vj_in;
    logic [INSTRUCTION_WIDTH-1:0] alu_vk_in;
    logic [INSTRUCTION_WIDTH-1:0] alu_A_in;
    logic [ROB_WIDTH-1:0]         alu_dest_in;
    logic [ADDRESS_WIDTH-1:0]     alu_pc_in;
    logic [INST_TYPE_WIDTH-1:0]   alu_inst_type_in;

    logic                         cdb_alu_en_out;
    logic [ROB_WIDTH-1:0]         cdb_alu_dest_out;
    logic [INSTRUCTION_WIDTH-1:0] cdb_alu_value_out;
    logic                         cdb_alu_jump_out;
    logic [ADDRESS_WIDTH-1:0]     cdb_alu_target_out;

    modport slave (
        input  alu_en_in, alu_vj_in, alu_vk_in, alu_A_in, alu_dest_in,
               alu_pc_in, alu_inst_type_in,
        output cdb_alu_en_out, cdb_alu_dest_out, cdb_alu_value_out,
               cdb_alu_jump_out, cdb_alu_target_out
    );

    modport master (
        output alu_en_in, alu_vj_in, alu_vk_in, alu_A_in, alu_dest_in,
               alu_pc_in, alu_inst_type_in,
        input  cdb_alu_en_out, cdb_alu_dest_out, cdb_alu_value_out,
               cdb_alu_jump_out, cdb_alu_target_out
    );
endinterface

// File: rtl/alu.sv
// alu
//   Single-issue integer execute stage. Accepts one instruction per cycle
//   from the RS and broadcasts the result (rd value, taken flag, next PC)
//   on the ALU CDB one cycle later.
//   Ports:
//     clk_in       : clock, rising edge
//     rst_in       : asynchronous active-low reset, clears all outputs
//     rdy_in       : global ready; when low every register holds
//     rob_flush_in : misprediction flush; kills the broadcast and any issue
//     bus          : alu_if.slave (issue inputs, CDB outputs)
module alu
    import alu_pkg::*;
(
    input  logic  clk_in,
    input  logic  rst_in,
    input  logic  rdy_in,
    input  logic  rob_flush_in,
    alu_if.slave  bus
);

    logic [31:0] vj, vk, imm, pc, pc_plus4;
    logic [4:0]  shamt_r, shamt_i;

    logic        res_jump;
    logic [31:0] res_value, res_target;

    logic                 en_q,     en_d;
    logic [ROB_WIDTH-1:0] dest_q,   dest_d;
    logic [31:0]          value_q,  value_d;
    logic                 jump_q,   jump_d;
    logic [31:0]          target_q, target_d;

    assign vj       = bus.alu_vj_in;
    assign vk       = bus.alu_vk_in;
    assign imm      = bus.alu_A_in;
    assign pc       = bus.alu_pc_in;
    assign pc_plus4 = pc + 32'd4;
    assign shamt_r  = vk[4:0];
    assign shamt_i  = imm[4:0];

    // Result computation; unknown types fall through to value=0, not taken.
    always_comb begin
        res_value  = '0;
        res_jump   = 1'b0;
        res_target = pc_plus4;
        case (bus.alu_inst_type_in)
            ADD:   res_value = vj + vk;
            SUB:   res_value = vj - vk;
            XOR:   res_value = vj ^ vk;
            OR:    res_value = vj | vk;
            AND:   res_value = vj & vk;
            SLL:   res_value = vj << shamt_r;
            SRL:   res_value = vj >> shamt_r;
            SRA:   res_value = $unsigned($signed(vj) >>> shamt_r);
            SLT:   res_value = {31'd0, $signed(vj) < $signed(vk)};
            SLTU:  res_value = {31'd0, vj < vk};
            ADDI:  res_value = vj + imm;
            XORI:  res_value = vj ^ imm;
            ORI:   res_value = vj | imm;
            ANDI:  res_value = vj & imm;
            SLLI:  res_value = vj << shamt_i;
            SRLI:  res_value = vj >> shamt_i;
            SRAI:  res_value = $unsigned($signed(vj) >>> shamt_i);
            SLTI:  res_value = {31'd0, $signed(vj) < $signed(imm)};
            SLTIU: res_value = {31'd0, vj < imm};
            LUI:   res_value = imm;
            AUIPC: res_value = pc + imm;
            JAL: begin
                res_value  = pc_plus4;
                res_jump   = 1'b1;
                res_target = pc + imm;
            end
            JALR: begin
                res_value  = pc_plus4;
                res_jump   = 1'b1;
                res_target = (vj + imm) & 32'hFFFF_FFFE;
            end
            BEQ:   res_jump = (vj == vk);
            BNE:   res_jump = (vj != vk);
            BLT:   res_jump = ($signed(vj) <  $signed(vk));
            BGE:   res_jump = ($signed(vj) >= $signed(vk));
            BLTU:  res_jump = (vj <  vk);
            BGEU:  res_jump = (vj >= vk);
            default: ;
        endcase
        // Branch target resolution shares the taken flag computed above.
        if (res_jump && (bus.alu_inst_type_in != JAL) && (bus.alu_inst_type_in != JALR)) begin
            res_target = pc + imm;
        end
    end

    // Payload only updates on an accepted issue so it holds while idle.
    always_comb begin
        en_d     = en_q;
        dest_d   = dest_q;
        value_d  = value_q;
        jump_d   = jump_q;
        target_d = target_q;
        if (rdy_in) begin
            if (rob_flush_in) begin
                en_d = 1'b0;
            end else begin
                en_d = bus.alu_en_in;
                if (bus.alu_en_in) begin
                    dest_d   = bus.alu_dest_in;
                    value_d  = res_value;
                    jump_d   = res_jump;
                    target_d = res_target;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            en_q     <= 1'b0;
            dest_q   <= '0;
            value_q  <= '0;
            jump_q   <= 1'b0;
            target_q <= '0;
        end else begin
            en_q     <= en_d;
            dest_q   <= dest_d;
            value_q  <= value_d;
            jump_q   <= jump_d;
            target_q <= target_d;
        end
    end

    assign bus.cdb_alu_en_out     = en_q;
    assign bus.cdb_alu_dest_out   = dest_q;
    assign bus.cdb_alu_value_out  = value_q;
    assign bus.cdb_alu_jump_out   = jump_q;
    assign bus.cdb_alu_target_out = target_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu
//   Directed-vector bench for the alu execute stage: reset, arithmetic,
//   compares, branches/jumps, back-to-back issue with flush, rdy stall.
module tb_alu;
    import alu_pkg::*;

    logic clk_in;
    logic rst_in;
    logic rdy_in;
    logic rob_flush_in;

    int unsigned n_checks;
    int unsigned n_fail;

    alu_if bus();

    alu u_dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .rob_flush_in (rob_flush_in),
        .bus          (bus.slave)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_cdb(input string tag, input logic en, input logic [31:0] dest,
                             input logic [31:0] value, input logic jump, input logic [31:0] target);
        check_eq({tag, ".en"},     {31'd0, bus.cdb_alu_en_out},     {31'd0, en});
        check_eq({tag, ".dest"},   {28'd0, bus.cdb_alu_dest_out},   dest);
        check_eq({tag, ".value"},  bus.cdb_alu_value_out,           value);
        check_eq({tag, ".jump"},   {31'd0, bus.cdb_alu_jump_out},   {31'd0, jump});
        check_eq({tag, ".target"}, bus.cdb_alu_target_out,          target);
    endtask

    task automatic drive(input logic [5:0] typ, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] a, input logic [31:0] pc, input logic [3:0] dest);
        bus.alu_en_in        = 1'b1;
        bus.alu_inst_type_in = typ;
        bus.alu_vj_in        = vj;
        bus.alu_vk_in        = vk;
        bus.alu_A_in         = a;
        bus.alu_pc_in        = pc;
        bus.alu_dest_in      = dest;
    endtask

    // Issue one instruction, then check the broadcast 1 time unit after the edge.
    task automatic do_op(input string tag, input logic [5:0] typ, input logic [31:0] vj,
                         input logic [31:0] vk, input logic [31:0] a, input logic [31:0] pc,
                         input logic [3:0] dest, input logic [31:0] exp_val,
                         input logic exp_jump, input logic [31:0] exp_tgt);
        @(negedge clk_in);
        drive(typ, vj, vk, a, pc, dest);
        @(posedge clk_in);
        #1;
        bus.alu_en_in = 1'b0;
        check_cdb(tag, 1'b1, {28'd0, dest}, exp_val, exp_jump, exp_tgt);
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst_in           = 1'b0;
        rdy_in           = 1'b1;
        rob_flush_in     = 1'b0;
        bus.alu_en_in    = 1'b0;
        bus.alu_vj_in    = '0;
        bus.alu_vk_in    = '0;
        bus.alu_A_in     = '0;
        bus.alu_pc_in    = '0;
        bus.alu_dest_in  = '0;
        bus.alu_inst_type_in = '0;

        #12;
        check_cdb("reset", 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Register ops
        do_op("add",  ADD,  32'h8000_0000, 32'h21, 32'd0, 32'h100, 4'd3, 32'h8000_0021, 1'b0, 32'h104);
        do_op("sub",  SUB,  32'h8000_0000, 32'h21, 32'd0, 32'h104, 4'd4, 32'h7FFF_FFDF, 1'b0, 32'h108);
        do_op("sra",  SRA,  32'h8000_0000, 32'h21, 32'd0, 32'h108, 4'd5, 32'hC000_0000, 1'b0, 32'h10C);
        do_op("srl",  SRL,  32'h8000_0000, 32'h21, 32'd0, 32'h10C, 4'd6, 32'h4000_0000, 1'b0, 32'h110);
        do_op("slt",  SLT,  32'hFFFF_FFFF, 32'd1,  32'd0, 32'h110, 4'd7, 32'd1,         1'b0, 32'h114);
        do_op("sltu", SLTU, 32'hFFFF_FFFF, 32'd1,  32'd0, 32'h114, 4'd8, 32'd0,         1'b0, 32'h118);
        // Immediate ops: shift uses A[4:0], vk must be ignored
        do_op("slli", SLLI, 32'h0000_0003, 32'h1F, 32'h24, 32'h200, 4'd9, 32'h0000_0030, 1'b0, 32'h204);
        do_op("srai", SRAI, 32'h8000_0000, 32'h0,  32'h1F, 32'h204, 4'd1, 32'hFFFF_FFFF, 1'b0, 32'h208);
        do_op("sltiu",SLTIU,32'd5,         32'd0,  32'hFFFF_FFFF, 32'h208, 4'd2, 32'd1, 1'b0, 32'h20C);
        do_op("lui",  LUI,  32'h1234_5678, 32'd0,  32'hABCD_E000, 32'h20C, 4'd3, 32'hABCD_E000, 1'b0, 32'h210);
        do_op("auipc",AUIPC,32'd0,         32'd0,  32'h0000_1000, 32'h210, 4'd4, 32'h0000_1210, 1'b0, 32'h214);
        // Control flow
        do_op("blt",  BLT,  32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 4'd5, 32'd0, 1'b1, 32'h120);
        do_op("bgeu", BGEU, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 4'd6, 32'd0, 1'b1, 32'h120);
        do_op("bltu", BLTU, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 4'd7, 32'd0, 1'b0, 32'h104);
        do_op("beq",  BEQ,  32'd9,         32'd9, 32'hFFFF_FFF0, 32'h100, 4'd8, 32'd0, 1'b1, 32'h0F0);
        do_op("jalr", JALR, 32'h203,       32'd0, 32'd0,  32'h100, 4'd9, 32'h104, 1'b1, 32'h202);
        do_op("jal",  JAL,  32'd0,         32'd0, 32'h40, 32'h300, 4'd10, 32'h304, 1'b1, 32'h340);
        do_op("unk",  6'h3F,32'hDEAD_BEEF, 32'd1, 32'h40, 32'h400, 4'd11, 32'd0, 1'b0, 32'h404);

        // Idle cycle: en drops, payload holds
        @(posedge clk_in); #1;
        check_cdb("idle", 1'b0, 32'd11, 32'd0, 1'b0, 32'h404);

        // Async reset while broadcasting
        do_op("prerst", ADD, 32'd1, 32'd2, 32'd0, 32'h500, 4'd12, 32'd3, 1'b0, 32'h504);
        #2;
        rst_in = 1'b0;
        #1;
        check_cdb("rst_mid", 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check_cdb("rst_rel", 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

        // Back-to-back issue, flush on the third edge
        do_op("b2b1", ADD, 32'd10, 32'd1, 32'd0, 32'h600, 4'd1, 32'd11, 1'b0, 32'h604);
        do_op("b2b2", SUB, 32'd10, 32'd1, 32'd0, 32'h604, 4'd2, 32'd9,  1'b0, 32'h608);
        @(negedge clk_in);
        drive(XOR, 32'hF0, 32'h0F, 32'd0, 32'h608, 4'd3);
        rob_flush_in = 1'b1;
        @(posedge clk_in); #1;
        check_cdb("flush", 1'b0, 32'd2, 32'd9, 1'b0, 32'h608);
        @(negedge clk_in);
        bus.alu_en_in = 1'b0;
        rob_flush_in  = 1'b0;
        @(posedge clk_in); #1;
        check_eq("post_flush.en", {31'd0, bus.cdb_alu_en_out}, 32'd0);

        // rdy stall while broadcasting
        do_op("stall0", OR, 32'hF0, 32'h0F, 32'd0, 32'h700, 4'd5, 32'hFF, 1'b0, 32'h704);
        @(negedge clk_in);
        rdy_in = 1'b0;
        drive(AND, 32'hF0, 32'h0F, 32'd0, 32'h800, 4'd6);
        for (int unsigned i = 0; i < 3; i++) begin
            @(posedge clk_in); #1;
            check_cdb($sformatf("stall%0d", i + 1), 1'b1, 32'd5, 32'hFF, 1'b0, 32'h704);
            @(negedge clk_in);
            bus.alu_en_in = ~bus.alu_en_in;
            rob_flush_in  = (i == 1);
        end
        rdy_in        = 1'b1;
        rob_flush_in  = 1'b0;
        bus.alu_en_in = 1'b0;
        @(posedge clk_in); #1;
        check_cdb("unstall", 1'b0, 32'd5, 32'hFF, 1'b0, 32'h704);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
